simple_axis_fifo_b2s: RTL
=========================

# simple_axis_fifo_b2s

AXI-Stream FIFO with a big-to-small width converter. Wide words (with tlast) are buffered in a first-word-fall-through store. A serializer then emits each word as RATIO = DATA_IN_WIDTH/DATA_OUT_WIDTH narrow beats, least-significant slice first. It sits at the read side of wide datapaths, unpacking them back onto narrow streams, and is the counterpart of the small-to-big FIFO.

## Interface
- DATA_IN_WIDTH, 128, slave (wide) data width; must be an integer multiple of DATA_OUT_WIDTH.
- DATA_OUT_WIDTH, 16, master (narrow) data width. RATIO = DATA_IN_WIDTH/DATA_OUT_WIDTH ≥ 1.
- ADDR_WIDTH, 8, FIFO store depth DEPTH = 2**ADDR_WIDTH wide words; does not include the serializer holding register.
- clk  input  1  single clock, all logic rising-edge.
- rstn  input  1  reset, asynchronous, active-low.
- s_axis_tdata  input  DATA_IN_WIDTH  wide word.
- s_axis_tlast  input  1  end of frame, marks the final wide word.
- s_axis_tvalid  input  1  slave valid.
- s_axis_tready  output  1  slave ready.
- m_axis_tdata  output  DATA_OUT_WIDTH  narrow beat.
- m_axis_tlast  output  1  end of frame, asserted on the final beat of a tlast word.
- m_axis_tvalid  output  1  master valid.
- m_axis_tready  input  1  master ready.
- wr_dat_cnt  output  ADDR_WIDTH+1  number of wide words in the store, range 0..DEPTH.

## Operation
- Store: DEPTH entries × (DATA_IN_WIDTH+1) bits holding {tlast, tdata}.
  - Write and read pointers are ADDR_WIDTH bits and wrap modulo DEPTH.
  - wr_dat_cnt is a registered counter.
- Write side:
  - s_axis_tready = (wr_dat_cnt != DEPTH). It is purely count-based, with no look-through on a same-cycle pop.
  - A write occurs on s_axis_tvalid & s_axis_tready.
- Serializer state machine:
  - State IDLE (hold_vld=0) or BUSY (hold_vld=1).
  - Holding register hold_dat[DATA_IN_WIDTH], hold_last, and beat counter beat[0..RATIO-1].
- Load: the head entry is popped into the holding register and beat is set to 0 when the store is non-empty and either:
  - the serializer is IDLE, or
  - the serializer is BUSY and the final beat (beat==RATIO-1) is accepted this cycle (back-to-back, no bubble).
- If the final beat is accepted and the store is empty, go to IDLE.
- Non-final accepted beat: beat+1 and shift hold_dat right by DATA_OUT_WIDTH.
- Outputs:
  - m_axis_tdata = hold_dat[DATA_OUT_WIDTH-1:0], so beat k carries input bits [k*DATA_OUT_WIDTH +: DATA_OUT_WIDTH].
  - m_axis_tvalid = hold_vld.
  - m_axis_tlast = hold_vld & hold_last & (beat==RATIO-1).
- Count update: +1 on write only, −1 on pop only, unchanged on simultaneous write and pop.
- Empty-store write and load in the same cycle: not permitted. The load uses registered count/pointers, so a new word is popped no earlier than the edge after its write.
- No tkeep. Frames must be whole wide words; every narrow beat of every word is emitted.
- RATIO==1: the serializer degenerates to a one-word output register; beat is held at 0.
- Reset (rstn low, asynchronous), effective immediately and mid-frame:
  - pointers, count, hold_vld, beat, hold_dat and hold_last all cleared;
  - outputs: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, wr_dat_cnt=0, s_axis_tready=1;
  - no partial word is emitted after release.

## Timing
- Latency: a word accepted at edge N appears as beat 0 with m_axis_tvalid=1 after edge N+1, when the serializer is IDLE.
- Throughput: with the store non-empty and m_axis_tready=1, one narrow beat per cycle, continuous across word boundaries.
- AXI rules on the master side:
  - m_axis_tvalid, m_axis_tdata and m_axis_tlast are stable while m_axis_tvalid & ~m_axis_tready;
  - tvalid is deasserted only after a handshake.
- Capacity: DEPTH+1 words before s_axis_tready drops (DEPTH in the store plus 1 in the holding register).
- s_axis_tready rises the cycle after the count leaves DEPTH.

## Test plan
Configuration DATA_IN_WIDTH=32, DATA_OUT_WIDTH=8, ADDR_WIDTH=2 unless stated.
- Single word: push 0x44332211 with tlast=1, m_axis_tready=1.
  - m_axis_tvalid is first high after edge N+1.
  - Beats 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles; tlast only with 0x44; then tvalid=0.
- Fill: m_axis_tready=0, offer words 1..6 continuously.
  - Exactly 5 accepted; wr_dat_cnt=4; s_axis_tready=0.
  - Release m_axis_tready: 20 beats in order, and s_axis_tready returns to 1 one cycle after the first pop.
- Streaming: 8 words back-to-back on both sides.
  - 32 contiguous beats with no tvalid bubble; tlast on beats 16 and 32 when words 4 and 8 carry tlast.
- Random backpressure (1000 words, random tvalid/tready): scoreboard shows identical byte order and tlast positions, and tdata/tlast stable during every stall.
- Reset mid-frame: assert rstn=0 during beat 2 of a word.
  - m_axis_tvalid drops without waiting for clk; wr_dat_cnt=0; s_axis_tready=1.
  - After release, no beats until new input.
- RATIO=1 (DATA_OUT_WIDTH=32): words pass unchanged with tlast preserved; capacity is 5.

Source files
------------

// File: rtl/simple_axis_fifo_b2s.sv
// simple_axis_fifo_b2s: FWFT store of wide {tlast, tdata} words feeding a serializer
// that emits each word as DATA_IN_WIDTH/DATA_OUT_WIDTH narrow beats, LS slice first.
module simple_axis_fifo_b2s #(
    parameter int DATA_IN_WIDTH  = 128,
    parameter int DATA_OUT_WIDTH = 16,
    parameter int ADDR_WIDTH     = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [DATA_IN_WIDTH-1:0]  s_axis_tdata,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [DATA_OUT_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [ADDR_WIDTH:0]       wr_dat_cnt
);
    localparam int RATIO = DATA_IN_WIDTH / DATA_OUT_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int BW = RATIO > 1 ? $clog2(RATIO) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    logic [DATA_IN_WIDTH:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0]    wr_ptr, rd_ptr;
    logic [DATA_IN_WIDTH-1:0] hold_dat;
    logic                     hold_last;
    logic [BW-1:0]            beat;
    state_t                   state;
    logic                     wr, fin, pop;

    assign s_axis_tready = wr_dat_cnt != FULL;
    assign wr            = s_axis_tvalid && s_axis_tready;
    assign fin           = state == BUSY && m_axis_tready && beat == LAST_BEAT;
    // Reload on the final beat's handshake keeps the output stream bubble-free.
    assign pop           = wr_dat_cnt != '0 && (state == IDLE || fin);
    assign m_axis_tvalid = state == BUSY;
    assign m_axis_tdata  = hold_dat[DATA_OUT_WIDTH-1:0];
    assign m_axis_tlast  = state == BUSY && hold_last && beat == LAST_BEAT;

    always_ff @(posedge clk)
        if (wr) mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_dat_cnt <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (wr != pop) wr_dat_cnt <= wr ? wr_dat_cnt + 1'b1 : wr_dat_cnt - 1'b1;
        end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state     <= IDLE;
            hold_dat  <= '0;
            hold_last <= 1'b0;
            beat      <= '0;
        end else if (pop) begin
            state                 <= BUSY;
            {hold_last, hold_dat} <= mem[rd_ptr];
            beat                  <= '0;
        end else if (fin) begin
            state <= IDLE;
        end else if (state == BUSY && m_axis_tready) begin
            beat     <= beat + 1'b1;
            hold_dat <= hold_dat >> DATA_OUT_WIDTH;
        end
endmodule
